imem_loader: RTL and testbench

Boot-time program loader and write-side counterpart of the CPU's instruction fetch path. It accepts a framed byte stream on a valid/ready interface and assembles 16-bit instructions, high byte first. Each instruction is written into instruction memory through its write port. The CPU is held in reset until a complete frame with a valid checksum has been written, and is then released.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader_word_asm.sv | 74 +++++++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// loader state encoding, default widths, sync marker and frame length constants.
package imem_loader_pkg;

    localparam int         LOADER_ADDR_W    = 8;
    localparam int         LOADER_DATA_W    = 16;
    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    // A LEN byte of zero encodes the largest frame, one word per PC value.
    localparam logic [7:0] LEN_FULL_FRAME   = 8'h00;
    localparam int         MAX_FRAME_WORDS  = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input plus instruction memory write port of the loader.
// The slave side is the loader; the master side feeds bytes and observes writes.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DATA_W = LOADER_DATA_W
) ();

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_waddr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_waddr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_loader_word_asm.sv
// Assembles 16-bit instructions from hi/lo stream bytes and keeps the running
// XOR checksum of the LEN byte and all payload bytes of the current frame.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_byte,
    input  logic                     take_len,
    input  logic                     take_hi,
    input  logic                     take_lo,
    output logic [7:0]               chk,
    output logic [LOADER_DATA_W-1:0] word,
    output logic                     word_valid
);

    logic [7:0] hi_reg;
    logic [7:0] chk_reg;
    logic       word_valid_reg;
    logic [7:0] lane_src [2];

    // Lane 1 carries the earlier (high) byte, lane 0 the byte on the bus now.
    assign lane_src[1] = hi_reg;
    assign lane_src[0] = in_byte;

    // Hold the high byte until its low partner arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_reg <= '0;
        end else if (take_hi) begin
            hi_reg <= in_byte;
        end
    end

    // Running checksum: seeded by LEN, folded with every payload byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_reg <= '0;
        end else if (take_len) begin
            chk_reg <= in_byte;
        end else if (take_hi || take_lo) begin
            chk_reg <= chk_reg ^ in_byte;
        end
    end

    // One-cycle write strobe following every low byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= take_lo;
        end
    end

    // Word register, one byte lane per generate instance; holds between writes.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [7:0] lane_reg;

        // Capture this lane when the low byte completes the word.
        always_ff @(posedge clk) begin
            if (!rst) begin
                lane_reg <= '0;
            end else if (take_lo) begin
                lane_reg <= lane_src[gi];
            end
        end

        assign word[gi*8 +: 8] = lane_reg;
    end

    assign chk        = chk_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses SYNC/LEN/payload/CHK frames from a byte
// stream, writes each assembled instruction into instruction memory and holds
// the CPU in reset until a frame with a matching checksum has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = LOADER_ADDR_W,
    parameter int         DATA_W    = LOADER_DATA_W,
    parameter logic [7:0] SYNC_BYTE = LOADER_SYNC_BYTE
) (
    input  logic            clk,
    input  logic            rst,
    imem_loader_if.slave    bus,
    input  logic            reload,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] words_loaded
);

    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_WORDS = (ADDR_W+1)'(MAX_FRAME_WORDS);

    loader_state_t     state_reg;
    loader_state_t     state_next;

    logic [ADDR_W:0]   len_words_reg;
    logic [ADDR_W:0]   words_loaded_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic              load_done_reg;
    logic              load_err_reg;
    logic              cpu_hold_reg;

    logic              accept;
    logic              take_len;
    logic              take_hi;
    logic              take_lo;
    logic              take_chk;
    logic              last_word;
    logic              chk_match;
    logic [7:0]        chk;
    logic [DATA_W-1:0] word;
    logic              word_valid;

    assign bus.in_ready = (state_reg != ST_DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign take_len     = accept && (state_reg == ST_LEN);
    assign take_hi      = accept && (state_reg == ST_HI);
    assign take_lo      = accept && (state_reg == ST_LO);
    assign take_chk     = accept && (state_reg == ST_CHK);

    // The word being completed now is the last one when the count reaches LEN.
    assign last_word    = ((words_loaded_reg + COUNT_ONE) == len_words_reg);
    assign chk_match    = (bus.in_data == chk);

    loader_word_asm u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .in_byte    (bus.in_data),
        .take_len   (take_len),
        .take_hi    (take_hi),
        .take_lo    (take_lo),
        .chk        (chk),
        .word       (word),
        .word_valid (word_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame parser next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && (bus.in_data == SYNC_BYTE)) state_next = ST_LEN;
            ST_LEN:  if (accept) state_next = ST_HI;
            ST_HI:   if (accept) state_next = ST_LO;
            ST_LO:   if (accept) state_next = last_word ? ST_CHK : ST_HI;
            ST_CHK:  if (accept) state_next = chk_match ? ST_DONE : ST_ERR;
            ST_DONE: if (reload) state_next = ST_IDLE;
            ST_ERR:  if (accept && (bus.in_data == SYNC_BYTE)) state_next = ST_LEN;
            default: state_next = ST_IDLE;
        endcase
    end

    // Frame length, write address/count and load status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_words_reg    <= '0;
            words_loaded_reg <= '0;
            waddr_reg        <= '0;
            load_done_reg    <= 1'b0;
            load_err_reg     <= 1'b0;
            cpu_hold_reg     <= 1'b1;
        end else begin
            if (take_len) begin
                len_words_reg    <= (bus.in_data == LEN_FULL_FRAME) ? FULL_WORDS
                                    : {{(ADDR_W-7){1'b0}}, bus.in_data};
                words_loaded_reg <= '0;
                waddr_reg        <= '0;
                load_err_reg     <= 1'b0;
            end
            // The count of words already written is the index of this one;
            // its low bits wrap naturally after word 255 of a full frame.
            if (take_lo) begin
                waddr_reg        <= words_loaded_reg[ADDR_W-1:0];
                words_loaded_reg <= words_loaded_reg + COUNT_ONE;
            end
            if (take_chk) begin
                if (chk_match) begin
                    load_done_reg <= 1'b1;
                    load_err_reg  <= 1'b0;
                    cpu_hold_reg  <= 1'b0;
                end else begin
                    load_err_reg  <= 1'b1;
                end
            end
            if ((state_reg == ST_DONE) && reload) begin
                cpu_hold_reg  <= 1'b1;
                load_done_reg <= 1'b0;
            end
        end
    end

    assign bus.imem_we    = word_valid;
    assign bus.imem_wdata = word;
    assign bus.imem_waddr = waddr_reg;
    assign cpu_hold       = cpu_hold_reg;
    assign load_done      = load_done_reg;
    assign load_err       = load_err_reg;
    assign words_loaded   = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench for imem_loader with randomized payloads. A frame
// level model predicts every memory write (cycle, address, data) and the final
// status; a monitor records the writes the DUT actually makes.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reload = 1'b0;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;
    logic [8:0] words_loaded;

    imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .reload       (reload),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write records: {cycle, address, data}
    logic [55:0] got_q [$];
    logic [55:0] exp_q [$];

    always @(negedge clk) begin
        if (bus.imem_we !== 1'b0) got_q.push_back({cyc, bus.imem_waddr, bus.imem_wdata});
    end

    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    bit          rnd_reload = 1'b0;
    bit          throttle = 1'b0;
    int          last_wr_cyc = 0;
    logic [15:0] fixed_w [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            reload = 1'b0;
        end
    endtask

    // Presents one byte until it is accepted at the next rising edge.
    task automatic send_byte(input logic [7:0] b, input bit allow_reload);
        bit got = 1'b0;
        if (throttle) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            reload = 1'b0;
            if (bus.in_ready === 1'b1) begin
                reload = (allow_reload && rnd_reload) ? 1'($urandom_range(0, 1)) : 1'b0;
                got = 1'b1;
                last_wr_cyc = cyc + 1;
                break;
            end
        end
        if (!got) check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    endtask

    // mode 0: random words, 1: word = index, 2: fixed_w[]
    task automatic send_frame(input logic [7:0] len_byte, input bit bad, input int mode,
                              input bit chk_len_clear);
        int          n;
        logic [7:0]  sum;
        logic [15:0] w;
        n   = (len_byte == 8'd0) ? 256 : int'(len_byte);
        sum = len_byte;
        send_byte(LOADER_SYNC_BYTE, 1'b1);
        send_byte(len_byte, 1'b1);
        if (chk_len_clear) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            reload = 1'b0;
            check("len_clears_err", {63'd0, load_err}, 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            if (mode == 1)      w = 16'(i);
            else if (mode == 2) w = fixed_w[i];
            else                w = 16'($urandom);
            send_byte(w[15:8], 1'b1);
            send_byte(w[7:0], 1'b1);
            exp_q.push_back({last_wr_cyc, 8'(i), w});
            sum = sum ^ w[15:8] ^ w[7:0];
        end
        send_byte(bad ? (sum ^ 8'h01) : sum, 1'b0);
        idle(3);
        $display("frame len=%0d words=%0d chk=%02h bad=%0d", len_byte, n, sum, bad);
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_write"}, {8'd0, got_q[i]}, {8'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag, input int words, input bit done, input bit err);
        check({tag, "_words"},     64'(words_loaded), 64'(words));
        check({tag, "_done"},      {63'd0, load_done}, {63'd0, done});
        check({tag, "_err"},       {63'd0, load_err}, {63'd0, err});
        check({tag, "_hold"},      {63'd0, cpu_hold}, {63'd0, !done});
        check({tag, "_ready"},     {63'd0, bus.in_ready}, {63'd0, !done});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, "_hold"},  {63'd0, cpu_hold}, 64'd1);
        check({tag, "_we"},    {63'd0, bus.imem_we}, 64'd0);
        check({tag, "_waddr"}, 64'(bus.imem_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
        check({tag, "_done"},  {63'd0, load_done}, 64'd0);
        check({tag, "_err"},   {63'd0, load_err}, 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic do_reload();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload_hold",  {63'd0, cpu_hold}, 64'd1);
        check("reload_ready", {63'd0, bus.in_ready}, 64'd1);
        check("reload_done",  {63'd0, load_done}, 64'd0);
    endtask

    initial begin
        logic [15:0] w;
        int          n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        fixed_w[0] = 16'h1234;
        fixed_w[1] = 16'hABCD;
        fixed_w[2] = 16'h0000;
        fixed_w[3] = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        rnd_reload = 1'b1;

        // Normal two-word frame
        send_frame(8'h02, 1'b0, 2, 1'b0);
        check_writes("normal");
        check_status("normal", 2, 1'b1, 1'b0);

        // In DONE, valid bytes are refused and nothing changes
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = LOADER_SYNC_BYTE;
            check("done_not_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        idle(2);
        check_writes("done_hold");
        check_status("done_hold", 2, 1'b1, 1'b0);
        do_reload();

        // Bad checksum: writes happen, CPU stays held
        send_frame(8'h02, 1'b1, 2, 1'b0);
        check_writes("badchk");
        check_status("badchk", 2, 1'b0, 1'b1);

        // Garbage in ERR is discarded; then a good frame clears the error
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(2);
        check_writes("err_garbage");
        check_status("err_garbage", 2, 1'b0, 1'b1);
        n = $urandom_range(1, 6);
        send_frame(8'(n), 1'b0, 0, 1'b1);
        check_writes("recover");
        check_status("recover", n, 1'b1, 1'b0);
        do_reload();

        // Garbage before sync, then a one-word frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        idle(1);
        check("garbage_no_write", 64'(got_q.size()), 64'd0);
        send_frame(8'h01, 1'b0, 0, 1'b0);
        check_writes("garbage");
        check_status("garbage", 1, 1'b1, 1'b0);
        do_reload();

        // Full 256-word frame, data = index
        send_frame(8'h00, 1'b0, 1, 1'b0);
        check_writes("full");
        check_status("full", 256, 1'b1, 1'b0);
        do_reload();

        // Reset after the high byte of the third word
        send_byte(LOADER_SYNC_BYTE, 1'b1);
        send_byte(8'h05, 1'b1);
        for (int i = 0; i < 2; i++) begin
            w = 16'($urandom);
            send_byte(w[15:8], 1'b1);
            send_byte(w[7:0], 1'b1);
            exp_q.push_back({last_wr_cyc, 8'(i), w});
        end
        send_byte(8'h77, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reload = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_outputs("midrst");
        idle(3);
        check_writes("midrst");
        $display("frame aborted by reset after word 2 hi byte");

        // New frame after reset starts at address 0
        n = $urandom_range(1, 8);
        send_frame(8'(n), 1'b0, 0, 1'b0);
        check_writes("postrst");
        check_status("postrst", n, 1'b1, 1'b0);
        do_reload();

        // Throttled stream: valid every other cycle
        throttle = 1'b1;
        n = $urandom_range(3, 10);
        send_frame(8'(n), 1'b0, 0, 1'b0);
        throttle = 1'b0;
        check_writes("throttle");
        check_status("throttle", n, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
